sme_driver: RTL and testbench

SME_DRIVER -- requirements
Module: sme_driver

---
 rtl/sme_driver_if.sv | 39 +++
 rtl/sme_driver.sv | 143 ++++++++++++++
 tb/tb_sme_driver.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_driver_if.sv
// Host, engine and status signals of the matching-engine driver.
// master = host/engine side, slave = driver side.
interface sme_driver_if;
    logic       wr_en;
    logic       wr_sel;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic       start;
    logic       send_str;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;
    logic       busy;
    logic       done;
    logic       result_match;
    logic [4:0] result_index;
    logic       timeout;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data,
        output str_len, pat_len, start, send_str,
        output valid, match, match_index,
        input  chardata, isstring, ispattern,
        input  busy, done, result_match, result_index, timeout
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data,
        input  str_len, pat_len, start, send_str,
        input  valid, match, match_index,
        output chardata, isstring, ispattern,
        output busy, done, result_match, result_index, timeout
    );
endinterface

// File: rtl/sme_driver.sv
// Streams a stored string and pattern to a string-matching engine and
// captures the engine result, abandoning the job after TIMEOUT cycles.
module sme_driver #(
    parameter int TIMEOUT = 64
) (
    input logic         clk,
    input logic         reset,
    sme_driver_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND_STR = 3'd1;
    localparam logic [2:0] SEND_PAT = 3'd2;
    localparam logic [2:0] WAIT     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam int            WW        = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

    logic [2:0]    state;
    logic [7:0]    str_buf [32];
    logic [7:0]    pat_buf [8];
    logic          str_loaded;
    logic [5:0]    str_len_q;
    logic [3:0]    pat_len_q;
    logic [5:0]    idx;
    logic [5:0]    nidx;
    logic [WW-1:0] wait_cnt;
    logic          pat_ok;
    logic          str_ok;
    logic          start_ok;

    assign nidx = idx + 6'd1;

    assign pat_ok = (bus.pat_len != 4'd0) && (bus.pat_len <= 4'd8);
    assign str_ok = (bus.str_len != 6'd0) && (bus.str_len <= 6'd32);

    // pattern-only jobs reuse the string already held by the engine
    assign start_ok = bus.start && pat_ok &&
                      (bus.send_str ? str_ok : str_loaded);

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                str_buf[i] <= 8'h00;
            end
            for (int i = 0; i < 8; i++) begin
                pat_buf[i] <= 8'h00;
            end
        end else if (state == IDLE && bus.wr_en) begin
            if (bus.wr_sel) begin
                pat_buf[bus.wr_addr[2:0]] <= bus.wr_data;
            end else begin
                str_buf[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            str_loaded       <= 1'b0;
            str_len_q        <= 6'd0;
            pat_len_q        <= 4'd0;
            idx              <= 6'd0;
            wait_cnt         <= '0;
            bus.chardata     <= 8'h00;
            bus.isstring     <= 1'b0;
            bus.ispattern    <= 1'b0;
            bus.result_match <= 1'b0;
            bus.result_index <= 5'd0;
            bus.timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        str_len_q <= bus.str_len;
                        pat_len_q <= bus.pat_len;
                        idx       <= 6'd0;
                        if (bus.send_str) begin
                            state        <= SEND_STR;
                            bus.chardata <= str_buf[0];
                            bus.isstring <= 1'b1;
                        end else begin
                            state         <= SEND_PAT;
                            bus.chardata  <= pat_buf[0];
                            bus.ispattern <= 1'b1;
                        end
                    end
                end
                SEND_STR: begin
                    // hand over straight to the pattern with no idle gap
                    if (nidx == str_len_q) begin
                        state         <= SEND_PAT;
                        idx           <= 6'd0;
                        str_loaded    <= 1'b1;
                        bus.chardata  <= pat_buf[0];
                        bus.isstring  <= 1'b0;
                        bus.ispattern <= 1'b1;
                    end else begin
                        idx          <= nidx;
                        bus.chardata <= str_buf[nidx[4:0]];
                    end
                end
                SEND_PAT: begin
                    if (nidx == {2'b00, pat_len_q}) begin
                        state         <= WAIT;
                        wait_cnt      <= '0;
                        bus.chardata  <= 8'h00;
                        bus.ispattern <= 1'b0;
                    end else begin
                        idx          <= nidx;
                        bus.chardata <= pat_buf[nidx[2:0]];
                    end
                end
                WAIT: begin
                    if (bus.valid) begin
                        state            <= DONE;
                        bus.result_match <= bus.match;
                        bus.result_index <= bus.match_index;
                        bus.timeout      <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state            <= DONE;
                        bus.result_match <= 1'b0;
                        bus.result_index <= 5'd31;
                        bus.timeout      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sme_driver.sv
// Randomized self-checking bench for sme_driver against a cycle-trace
// model built from the job rules.
module tb_sme_driver;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;

    sme_driver_if bus ();

    sme_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] str_m [32];
    logic [7:0] pat_m [8];
    bit         str_loaded_m;
    bit         res_m;
    logic [4:0] res_i;
    bit         res_t;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
        return {13'd0, bus.timeout, bus.result_match, bus.result_index,
                bus.busy, bus.done, bus.isstring, bus.ispattern,
                bus.chardata};
    endfunction

    function automatic logic [31:0] expv(bit b, bit d, bit s, bit p,
                                         logic [7:0] c);
        return {13'd0, res_t, res_m, res_i, b, d, s, p, c};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) str_m[i] = 8'h00;
        for (int i = 0; i < 8; i++) pat_m[i] = 8'h00;
        str_loaded_m = 0;
        res_m = 0;
        res_i = 5'd0;
        res_t = 0;
    endtask

    task automatic wr(bit sel, logic [4:0] a, logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_sel = sel;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        if (sel) pat_m[a[2:0]] = d;
        else str_m[a] = d;
    endtask

    // vd: WAIT cycle (0-based) in which valid is given, -1 = never.
    // rst_at: stream cycle after which reset is pulsed, -1 = none.
    // noisy: pulse start and wr_en on every stream cycle.
    task automatic run_job(bit ss, int sl, int pl, int vd, bit m,
                           logic [4:0] mi, int rst_at, bit noisy);
        logic [7:0] q [$];
        bit         qs [$];
        bit         acc;
        int         nw;
        acc = (pl >= 1) && (pl <= 8) &&
              (ss ? ((sl >= 1) && (sl <= 32)) : str_loaded_m);
        bus.start = 1'b1;
        bus.send_str = ss;
        bus.str_len = 6'(sl);
        bus.pat_len = 4'(pl);
        step();
        bus.start = 1'b0;
        bus.str_len = 6'($urandom);
        bus.pat_len = 4'($urandom);
        if (!acc) begin
            for (int i = 0; i < 3; i++) begin
                chk("blocked", obs(), expv(0, 0, 0, 0, 8'h00));
                step();
            end
            return;
        end
        if (ss) begin
            for (int i = 0; i < sl; i++) begin
                q.push_back(str_m[i]);
                qs.push_back(1'b1);
            end
        end
        for (int i = 0; i < pl; i++) begin
            q.push_back(pat_m[i]);
            qs.push_back(1'b0);
        end
        foreach (q[i]) begin
            chk("stream", obs(), expv(1, 0, qs[i], !qs[i], q[i]));
            if (i + 1 == rst_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                model_reset();
                chk("reset_mid", obs(), expv(0, 0, 0, 0, 8'h00));
                return;
            end
            bus.start = noisy || ($urandom_range(0, 3) == 0);
            bus.send_str = 1'($urandom);
            bus.wr_en = noisy || ($urandom_range(0, 3) == 0);
            bus.wr_sel = 1'($urandom);
            bus.wr_addr = 5'($urandom);
            bus.wr_data = 8'($urandom);
            bus.valid = 1'($urandom);
            bus.match = 1'($urandom);
            bus.match_index = 5'($urandom);
            step();
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            bus.valid = 1'b0;
        end
        if (ss) str_loaded_m = 1;
        nw = (vd >= 0) ? vd + 1 : TIMEOUT;
        for (int w = 0; w < nw; w++) begin
            chk("wait", obs(), expv(1, 0, 0, 0, 8'h00));
            if (w == vd) begin
                bus.valid = 1'b1;
                bus.match = m;
                bus.match_index = mi;
            end
            step();
            bus.valid = 1'b0;
        end
        if (vd >= 0) begin
            res_m = m;
            res_i = mi;
            res_t = 0;
        end else begin
            res_m = 0;
            res_i = 5'd31;
            res_t = 1;
        end
        chk("done", obs(), expv(1, 1, 0, 0, 8'h00));
        bus.valid = 1'($urandom);
        bus.match = 1'($urandom);
        bus.match_index = 5'($urandom);
        step();
        bus.valid = 1'b0;
        chk("idle", obs(), expv(0, 0, 0, 0, 8'h00));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        string hs;
        string ps;
        bit    ss;
        int    sl;
        int    pl;
        int    vd;
        int    ra;
        bus.wr_en = 1'b0;
        bus.wr_sel = 1'b0;
        bus.wr_addr = 5'd0;
        bus.wr_data = 8'h00;
        bus.str_len = 6'd0;
        bus.pat_len = 4'd0;
        bus.start = 1'b0;
        bus.send_str = 1'b0;
        bus.valid = 1'b0;
        bus.match = 1'b0;
        bus.match_index = 5'd0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        chk("reset", obs(), expv(0, 0, 0, 0, 8'h00));

        run_job(0, 0, 3, 0, 0, 5'd0, -1, 0);
        run_job(1, 11, 9, 0, 0, 5'd0, -1, 0);
        run_job(1, 0, 3, 0, 0, 5'd0, -1, 0);
        run_job(1, 33, 3, 0, 0, 5'd0, -1, 0);
        run_job(1, 5, 0, 0, 0, 5'd0, -1, 0);

        hs = "hello world";
        ps = "wor";
        for (int i = 0; i < hs.len(); i++) wr(0, 5'(i), hs[i]);
        for (int i = 0; i < ps.len(); i++) wr(1, 5'(i), ps[i]);
        run_job(1, 11, 3, 2, 1, 5'd6, -1, 0);
        chk("s1_index", 32'(bus.result_index), 32'd6);

        ps = "xyz";
        for (int i = 0; i < ps.len(); i++) wr(1, 5'(i + 8), ps[i]);
        run_job(0, 0, 3, 0, 0, 5'd4, -1, 0);

        run_job(0, 0, 3, -1, 1, 5'd9, -1, 0);
        chk("s3_timeout", 32'(bus.timeout), 32'd1);

        run_job(1, 32, 8, TIMEOUT - 1, 1, 5'd17, -1, 0);
        run_job(1, 1, 1, 0, 1, 5'd0, -1, 0);

        run_job(0, 0, 3, 4, 1, 5'd3, -1, 1);
        run_job(0, 0, 3, 1, 0, 5'd9, -1, 0);

        run_job(1, 11, 3, 0, 0, 5'd0, 5, 0);
        run_job(0, 0, 3, 0, 0, 5'd0, -1, 0);

        repeat (40) begin
            repeat ($urandom_range(0, 6)) begin
                wr(1'($urandom), 5'($urandom), 8'($urandom));
            end
            ss = 1'($urandom);
            sl = ($urandom_range(0, 7) == 0) ?
                 (($urandom_range(0, 1) == 0) ? 0 : 33) :
                 $urandom_range(1, 32);
            pl = ($urandom_range(0, 7) == 0) ?
                 (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15)) :
                 $urandom_range(1, 8);
            vd = ($urandom_range(0, 4) == 0) ? -1 :
                 $urandom_range(0, TIMEOUT - 1);
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : -1;
            run_job(ss, sl, pl, vd, 1'($urandom), 5'($urandom), ra, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
